// File: rtl/vec_add_engine.sv
// vec_add_engine
//   Host-memory vector adder for the CCI-P add-numbers AFU. After an accepted
//   start it walks num_lines cache lines: read line i from src_addr+i, add
//   adjacent element pairs in every lane, write the packed sums (upper half of
//   the line zero) to dst_addr+i. Exactly one request is outstanding at a time.
//
// Build option:
//   VEC_ADD_SATURATE_EN  defined   -> a lane that carries saturates to all-ones
//                        undefined -> a lane wraps modulo 2^DATA_W
//   In both builds a carry sets the sticky overflow flag.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle start pulse (ignored while busy)
//   src_addr, dst_addr    first source / destination line address
//   num_lines             number of lines to process (0 allowed)
//   rd_req_valid/_addr    c0 read request (registered pulse)
//   rd_almfull            c0 TX almost-full
//   rd_rsp_valid/_data    c0 read response
//   wr_req_valid/_addr/_data  c1 write request (registered pulse, sop implied)
//   wr_almfull            c1 TX almost-full
//   wr_rsp_valid          c1 write response
//   busy, done, overflow  run status (done and overflow are sticky)
//   lines_done            write responses received in the current run
module vec_add_engine #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 512,
  parameter int ADDR_W = 42,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  num_lines,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_almfull,
  input  logic              rd_rsp_valid,
  input  logic [LINE_W-1:0] rd_rsp_data,
  output logic              wr_req_valid,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [LINE_W-1:0] wr_req_data,
  input  logic              wr_almfull,
  input  logic              wr_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  lines_done
);

  localparam int LANES  = LINE_W / (2 * DATA_W);
  localparam int HALF_W = LANES * DATA_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_start_acc;
  logic w_rd_fire;
  logic w_rsp_cap;
  logic w_wr_fire;
  logic w_wr_ack;
  logic w_last;

  logic [ADDR_W-1:0] r_src_cur;
  logic [ADDR_W-1:0] r_dst_cur;
  logic [CNT_W-1:0]  r_remain;
  logic [CNT_W-1:0]  r_lines_done;
  logic              r_rd_req_valid;
  logic              r_wr_req_valid;
  logic              r_done;
  logic              r_overflow;
  logic [HALF_W-1:0] r_res_p1;

  logic [HALF_W-1:0] w_res_p0;
  logic [LANES-1:0]  w_carry_p0;

`ifdef VEC_ADD_SATURATE_EN
  function automatic logic [DATA_W-1:0] sat_lane(input logic [DATA_W:0] sum);
    return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  endfunction
`endif

  // ---- stage p0: lane adders straight off the read response bus ----
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DATA_W:0] w_sum;
    assign w_sum = {1'b0, rd_rsp_data[(2*k)*DATA_W +: DATA_W]}
                 + {1'b0, rd_rsp_data[(2*k+1)*DATA_W +: DATA_W]};
    assign w_carry_p0[k] = w_sum[DATA_W];
`ifdef VEC_ADD_SATURATE_EN
    assign w_res_p0[k*DATA_W +: DATA_W] = sat_lane(w_sum);
`else
    assign w_res_p0[k*DATA_W +: DATA_W] = w_sum[DATA_W-1:0];
`endif
  end

  assign w_last = (r_remain == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_rd_fire   = 1'b0;
    w_rsp_cap   = 1'b0;
    w_wr_fire   = 1'b0;
    w_wr_ack    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (num_lines == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!rd_almfull) begin
          w_rd_fire   = 1'b1;
          w_state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rd_rsp_valid) begin
          w_rsp_cap   = 1'b1;
          w_state_nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (!wr_almfull) begin
          w_wr_fire   = 1'b1;
          w_state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_rsp_valid) begin
          w_wr_ack    = 1'b1;
          w_state_nxt = w_last ? DONE : RD_REQ;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: captured result line, request pulses and run status ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_cur      <= '0;
      r_dst_cur      <= '0;
      r_remain       <= '0;
      r_lines_done   <= '0;
      r_rd_req_valid <= 1'b0;
      r_wr_req_valid <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
      r_res_p1       <= '0;
    end else begin
      r_rd_req_valid <= w_rd_fire;
      r_wr_req_valid <= w_wr_fire;
      if (w_start_acc) begin
        r_src_cur    <= src_addr;
        r_dst_cur    <= dst_addr;
        r_remain     <= num_lines;
        r_lines_done <= '0;
        r_done       <= 1'b0;
        r_overflow   <= 1'b0;
      end
      if (w_rsp_cap) begin
        r_res_p1 <= w_res_p0;
        if (|w_carry_p0) r_overflow <= 1'b1;
      end
      if (w_wr_ack) begin
        r_lines_done <= r_lines_done + CNT_W'(1);
        r_remain     <= r_remain - CNT_W'(1);
        // Keep the addresses of the final line visible after completion.
        if (!w_last) begin
          r_src_cur <= r_src_cur + ADDR_W'(1);
          r_dst_cur <= r_dst_cur + ADDR_W'(1);
        end
      end
      if (r_state == DONE) r_done <= 1'b1;
    end
  end

  assign rd_req_valid = r_rd_req_valid;
  assign rd_req_addr  = r_src_cur;
  assign wr_req_valid = r_wr_req_valid;
  assign wr_req_addr  = r_dst_cur;
  assign wr_req_data  = {{(LINE_W-HALF_W){1'b0}}, r_res_p1};
  assign busy         = (r_state == RD_REQ) || (r_state == RD_WAIT) ||
                        (r_state == WR_REQ) || (r_state == WR_WAIT);
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign lines_done   = r_lines_done;

endmodule

// File: tb/tb_vec_add_engine.sv
module tb_vec_add_engine;
  localparam int LW = 512;
  localparam int AW = 42;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // DATA_W = 8 instance
  logic a_start, a_rd_v, a_rd_af, a_rsp_v, a_wr_v, a_wr_af, a_wrsp_v, a_busy, a_done, a_ovf;
  logic [AW-1:0] a_src, a_dst, a_rd_addr, a_wr_addr;
  logic [CW-1:0] a_num, a_lines;
  logic [LW-1:0] a_rsp_d, a_wr_d;

  // DATA_W = 16 instance
  logic b_start, b_rd_v, b_rd_af, b_rsp_v, b_wr_v, b_wr_af, b_wrsp_v, b_busy, b_done, b_ovf;
  logic [AW-1:0] b_src, b_dst, b_rd_addr, b_wr_addr;
  logic [CW-1:0] b_num, b_lines;
  logic [LW-1:0] b_rsp_d, b_wr_d;

  int errors = 0;
  int checks = 0;
  int a_rd_cnt = 0, a_wr_cnt = 0, b_rd_cnt = 0, b_wr_cnt = 0;

  vec_add_engine #(.DATA_W(8), .LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) u_dut8 (
    .clk(clk), .reset(reset), .start(a_start), .src_addr(a_src), .dst_addr(a_dst),
    .num_lines(a_num), .rd_req_valid(a_rd_v), .rd_req_addr(a_rd_addr), .rd_almfull(a_rd_af),
    .rd_rsp_valid(a_rsp_v), .rd_rsp_data(a_rsp_d), .wr_req_valid(a_wr_v),
    .wr_req_addr(a_wr_addr), .wr_req_data(a_wr_d), .wr_almfull(a_wr_af),
    .wr_rsp_valid(a_wrsp_v), .busy(a_busy), .done(a_done), .overflow(a_ovf),
    .lines_done(a_lines));

  vec_add_engine #(.DATA_W(16), .LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) u_dut16 (
    .clk(clk), .reset(reset), .start(b_start), .src_addr(b_src), .dst_addr(b_dst),
    .num_lines(b_num), .rd_req_valid(b_rd_v), .rd_req_addr(b_rd_addr), .rd_almfull(b_rd_af),
    .rd_rsp_valid(b_rsp_v), .rd_rsp_data(b_rsp_d), .wr_req_valid(b_wr_v),
    .wr_req_addr(b_wr_addr), .wr_req_data(b_wr_d), .wr_almfull(b_wr_af),
    .wr_rsp_valid(b_wrsp_v), .busy(b_busy), .done(b_done), .overflow(b_ovf),
    .lines_done(b_lines));

  // Request pulse counters
  always @(posedge clk) begin
    if (a_rd_v === 1'b1) a_rd_cnt <= a_rd_cnt + 1;
    if (a_wr_v === 1'b1) a_wr_cnt <= a_wr_cnt + 1;
    if (b_rd_v === 1'b1) b_rd_cnt <= b_rd_cnt + 1;
    if (b_wr_v === 1'b1) b_wr_cnt <= b_wr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (a_rd_v !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b want 0", a_rd_v); end
    checks++; if (a_wr_v !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b want 0", a_wr_v); end
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_ovf !== 1'b0) begin errors++;
      $display("FAIL rst_status: busy/done/ovf got %b%b%b want 000", a_busy, a_done, a_ovf); end
    checks++; if (a_lines !== '0) begin errors++; $display("FAIL rst_lines: got %0d want 0", a_lines); end
    checks++; if (a_rd_addr !== '0 || a_wr_addr !== '0) begin errors++;
      $display("FAIL rst_addr: rd %h wr %h want 0", a_rd_addr, a_wr_addr); end
    checks++; if (a_wr_d !== '0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", a_wr_d); end
    // start during reset must be ignored
    a_num = 16'd1; a_start = 1'b1;
    tick();
    reset = 1'b0; a_start = 1'b0;
    tick(); tick(); tick();
    checks++; if (a_busy !== 1'b0 || a_rd_cnt != 0) begin errors++;
      $display("FAIL rst_start_ignored: busy %b rd_reqs %0d want 0 0", a_busy, a_rd_cnt); end
  endtask

  task automatic test_basic();
    logic [LW-1:0] din, exp;
    int rd0, wr0;
    din = {{60{8'h11}}, 8'h20, 8'h10, 8'h07, 8'h05};
    exp = {256'b0, {30{8'h22}}, 8'h30, 8'h0C};
    rd0 = a_rd_cnt; wr0 = a_wr_cnt;
    a_src = 42'h100; a_dst = 42'h200; a_num = 16'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_rd_v !== 1'b0) begin errors++;
      $display("FAIL basic_cycle1: busy %b rd_v %b want 1 0", a_busy, a_rd_v); end
    tick();
    checks++; if (a_rd_v !== 1'b1 || a_rd_addr !== 42'h100) begin errors++;
      $display("FAIL basic_rd_req: rd_v %b addr %h want 1 100", a_rd_v, a_rd_addr); end
    a_rsp_v = 1'b1; a_rsp_d = din;
    tick();
    a_rsp_v = 1'b0; a_rsp_d = '0;
    checks++; if (a_rd_v !== 1'b0 || a_wr_v !== 1'b0) begin errors++;
      $display("FAIL basic_pulse_width: rd_v %b wr_v %b want 0 0", a_rd_v, a_wr_v); end
    tick();
    checks++; if (a_wr_v !== 1'b1 || a_wr_addr !== 42'h200) begin errors++;
      $display("FAIL basic_wr_req: wr_v %b addr %h want 1 200", a_wr_v, a_wr_addr); end
    checks++; if (a_wr_d !== exp) begin errors++;
      $display("FAIL basic_wr_data: got %h want %h", a_wr_d, exp); end
    a_wrsp_v = 1'b1;
    tick();
    a_wrsp_v = 1'b0;
    checks++; if (a_lines !== 16'd1 || a_busy !== 1'b0 || a_done !== 1'b0) begin errors++;
      $display("FAIL basic_ack: lines %0d busy %b done %b want 1 0 0", a_lines, a_busy, a_done); end
    tick();
    checks++; if (a_done !== 1'b1 || a_ovf !== 1'b0) begin errors++;
      $display("FAIL basic_done: done %b ovf %b want 1 0", a_done, a_ovf); end
    tick();
    checks++; if (a_rd_cnt - rd0 != 1 || a_wr_cnt - wr0 != 1) begin errors++;
      $display("FAIL basic_req_count: rd %0d wr %0d want 1 1", a_rd_cnt - rd0, a_wr_cnt - wr0); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b0;
`ifdef VEC_ADD_SATURATE_EN
    exp_b0 = 8'hFF;
`else
    exp_b0 = 8'h01;
`endif
    a_src = 42'h10; a_dst = 42'h20; a_num = 16'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_rsp_v = 1'b1; a_rsp_d = {{62{8'h00}}, 8'h02, 8'hFF};
    tick();
    a_rsp_v = 1'b0; a_rsp_d = '0;
    tick();
    checks++; if (a_wr_v !== 1'b1 || a_wr_d !== {504'b0, exp_b0}) begin errors++;
      $display("FAIL ovf_wr_data: wr_v %b data %h want 1 %h", a_wr_v, a_wr_d, exp_b0); end
    checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag_set: got %b want 1", a_ovf); end
    a_wrsp_v = 1'b1;
    tick();
    a_wrsp_v = 1'b0;
    tick();
    checks++; if (a_done !== 1'b1 || a_ovf !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky: done %b ovf %b want 1 1", a_done, a_ovf); end
  endtask

  task automatic test_zero_lines();
    int rd0, wr0;
    rd0 = a_rd_cnt; wr0 = a_wr_cnt;
    a_num = 16'd0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_done !== 1'b0 || a_ovf !== 1'b0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL zero_clear: done %b ovf %b busy %b want 0 0 0", a_done, a_ovf, a_busy); end
    tick();
    checks++; if (a_done !== 1'b1 || a_lines !== 16'd0) begin errors++;
      $display("FAIL zero_done: done %b lines %0d want 1 0", a_done, a_lines); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (a_rd_cnt != rd0 || a_wr_cnt != wr0) begin errors++;
      $display("FAIL zero_no_req: rd %0d wr %0d want 0 0", a_rd_cnt - rd0, a_wr_cnt - wr0); end
  endtask

  task automatic test_almfull_restart();
    int rd0;
    a_rd_af = 1'b1;
    a_src = 42'h300; a_dst = 42'h400; a_num = 16'd1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    rd0 = a_rd_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        a_start = 1'b1; a_src = 42'h555; a_dst = 42'h666; a_num = 16'd5;
      end else begin
        a_start = 1'b0;
      end
      tick();
      checks++; if (a_rd_v !== 1'b0 || a_busy !== 1'b1) begin errors++;
        $display("FAIL af_stall[%0d]: rd_v %b busy %b want 0 1", i, a_rd_v, a_busy); end
    end
    a_start = 1'b0; a_rd_af = 1'b0;
    tick();
    checks++; if (a_rd_v !== 1'b1 || a_rd_addr !== 42'h300) begin errors++;
      $display("FAIL af_release: rd_v %b addr %h want 1 300", a_rd_v, a_rd_addr); end
    a_rsp_v = 1'b1; a_rsp_d = {{62{8'h00}}, 8'h01, 8'h01};
    a_wr_af = 1'b1;
    tick();
    a_rsp_v = 1'b0; a_rsp_d = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_wr_v !== 1'b0) begin errors++;
        $display("FAIL wr_af_stall[%0d]: wr_v %b want 0", i, a_wr_v); end
    end
    a_wr_af = 1'b0;
    tick();
    checks++; if (a_wr_v !== 1'b1 || a_wr_addr !== 42'h400 || a_wr_d[7:0] !== 8'h02) begin errors++;
      $display("FAIL af_wr_req: wr_v %b addr %h d0 %h want 1 400 02", a_wr_v, a_wr_addr, a_wr_d[7:0]); end
    a_wrsp_v = 1'b1;
    tick();
    a_wrsp_v = 1'b0;
    tick();
    checks++; if (a_done !== 1'b1 || a_lines !== 16'd1 || a_rd_cnt - rd0 != 1) begin errors++;
      $display("FAIL af_done: done %b lines %0d rd_reqs %0d want 1 1 1", a_done, a_lines, a_rd_cnt - rd0); end
  endtask

  task automatic test_reset_mid_run();
    int rd0, wr0;
    a_src = 42'h20; a_dst = 42'h30; a_num = 16'd2; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_rsp_v = 1'b1;
    tick();
    a_rsp_v = 1'b0;
    tick();
    a_wrsp_v = 1'b1;
    tick();
    a_wrsp_v = 1'b0;
    tick();
    checks++; if (a_rd_v !== 1'b1 || a_rd_addr !== 42'h21) begin errors++;
      $display("FAIL mid_rd2: rd_v %b addr %h want 1 21", a_rd_v, a_rd_addr); end
    a_rsp_v = 1'b1;
    tick();
    a_rsp_v = 1'b0;
    tick();
    checks++; if (a_wr_v !== 1'b1 || a_wr_addr !== 42'h31 || a_lines !== 16'd1) begin errors++;
      $display("FAIL mid_wr2: wr_v %b addr %h lines %0d want 1 31 1", a_wr_v, a_wr_addr, a_lines); end
    reset = 1'b1;
    tick();
    reset = 1'b0; a_wrsp_v = 1'b1;
    tick();
    a_wrsp_v = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_lines !== 16'd0 || a_done !== 1'b0) begin errors++;
      $display("FAIL mid_reset: busy %b lines %0d done %b want 0 0 0", a_busy, a_lines, a_done); end
    rd0 = a_rd_cnt; wr0 = a_wr_cnt;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (a_rd_cnt != rd0 || a_wr_cnt != wr0 || a_busy !== 1'b0) begin errors++;
      $display("FAIL mid_no_req: rd %0d wr %0d busy %b want 0 0 0", a_rd_cnt - rd0, a_wr_cnt - wr0, a_busy); end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] exp_rd [3];
    logic [15:0]   din0 [3];
    logic [15:0]   exp0 [3];
    logic [LW-1:0] exp;
    exp_rd = '{42'h3FF_FFFF_FFFF, 42'h0, 42'h1};
    din0   = '{16'h1000, 16'h1001, 16'h1002};
    exp0   = '{16'h1001, 16'h1002, 16'h1003};
    b_src = 42'h3FF_FFFF_FFFF; b_dst = 42'h10; b_num = 16'd3; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_rd_v !== 1'b1 || b_rd_addr !== exp_rd[i]) begin errors++;
        $display("FAIL wrap_rd[%0d]: rd_v %b addr %h want 1 %h", i, b_rd_v, b_rd_addr, exp_rd[i]); end
      b_rsp_d = '0;
      b_rsp_d[15:0]  = din0[i];
      b_rsp_d[31:16] = 16'h0001;
      b_rsp_d[47:32] = 16'h00F0;
      b_rsp_d[63:48] = 16'h000F;
      b_rsp_v = 1'b1;
      tick();
      b_rsp_v = 1'b0; b_rsp_d = '0;
      tick();
      exp = {480'b0, 16'h00FF, exp0[i]};
      checks++; if (b_wr_v !== 1'b1 || b_wr_addr !== 42'h10 + 42'(i) || b_wr_d !== exp) begin errors++;
        $display("FAIL wrap_wr[%0d]: wr_v %b addr %h data %h want 1 %h %h", i, b_wr_v, b_wr_addr, b_wr_d, 42'h10 + 42'(i), exp); end
      b_wrsp_v = 1'b1;
      tick();
      b_wrsp_v = 1'b0;
      tick();
    end
    checks++; if (b_done !== 1'b1 || b_lines !== 16'd3 || b_busy !== 1'b0 || b_ovf !== 1'b0) begin errors++;
      $display("FAIL wrap_done: done %b lines %0d busy %b ovf %b want 1 3 0 0", b_done, b_lines, b_busy, b_ovf); end
    tick();
    checks++; if (b_rd_cnt != 3 || b_wr_cnt != 3) begin errors++;
      $display("FAIL wrap_req_count: rd %0d wr %0d want 3 3", b_rd_cnt, b_wr_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_src = '0; a_dst = '0; a_num = '0; a_rd_af = 1'b0; a_rsp_v = 1'b0;
    a_rsp_d = '0; a_wr_af = 1'b0; a_wrsp_v = 1'b0;
    b_start = 1'b0; b_src = '0; b_dst = '0; b_num = '0; b_rd_af = 1'b0; b_rsp_v = 1'b0;
    b_rsp_d = '0; b_wr_af = 1'b0; b_wrsp_v = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero_lines();
    test_almfull_restart();
    test_reset_mid_run();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
